// File: rtl/da_lut_accumulator.sv
// da_lut_accumulator: distributed-arithmetic FIR back end; eight partial-sum LUTs per bit-slice, MSB-first shift-accumulate
module da_lut_accumulator #(
  parameter int COEF_W = 16,
  parameter int DATA_W = 16,
  parameter int LUT_W  = COEF_W + 3,
  parameter int ACC_W  = COEF_W + 6 + DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [7:0]              A0,
  input  logic [7:0]              A1,
  input  logic [7:0]              A2,
  input  logic [7:0]              A3,
  input  logic [7:0]              A4,
  input  logic [7:0]              A5,
  input  logic [7:0]              A6,
  input  logic [7:0]              A7,
  input  logic                    lut_we,
  input  logic [2:0]              lut_sel,
  input  logic [7:0]              lut_addr,
  input  logic [LUT_W-1:0]        lut_wdata,
  output logic signed [ACC_W-1:0] y,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    err
);
  localparam int SUM_W = LUT_W + 3;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [LUT_W-1:0]        lut_q [8][256];
  logic signed [LUT_W-1:0] l_q [8];
  logic [7:0]              addr [8];
  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tag_q, tag_d;
  logic                    v1_q, f1_q, last1_q, tag1_q;
  logic                    v2_q, f2_q, last2_q, tag2_q;
  logic signed [SUM_W-1:0] s_q, sum;
  logic signed [ACC_W-1:0] acc_q, acc_d, y_q, y_d;
  logic                    y_valid_q, busy_q, busy_d, err_q, err_d;
  logic                    start, abort, drop, last, v1_d, take, issue;

  assign addr    = '{A0, A1, A2, A3, A4, A5, A6, A7};
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

  // LUT storage is deliberately outside reset so programmed tables survive it
  always_ff @(posedge clk) begin
    if (lut_we) lut_q[lut_sel][lut_addr] <= lut_wdata;
    for (int g = 0; g < 8; g++) l_q[g] <= lut_q[g][addr[g]];
  end

  always_comb begin
    start   = in_valid & in_first;
    abort   = start & (state_q == ACCUM);
    drop    = in_valid & ~in_first & (state_q == IDLE);
    last    = in_valid & ~in_first & (state_q == ACCUM) & (cnt_q == CNT_W'(DATA_W - 1));
    v1_d    = start | (in_valid & (state_q == ACCUM));
    state_d = start ? ACCUM : last ? IDLE : state_q;
    cnt_d   = start ? CNT_W'(1) : last ? '0 : v1_d ? cnt_q + 1'b1 : cnt_q;
    // an abort retires the old word's tag so its in-flight slices are ignored
    tag_d   = tag_q ^ abort;
    sum     = '0;
    for (int g = 0; g < 8; g++) sum = sum + SUM_W'(l_q[g]);
    take    = v2_q & (tag2_q == tag_q);
    acc_d   = take ? (f2_q ? -ACC_W'(s_q) : (acc_q <<< 1) + ACC_W'(s_q)) : acc_q;
    issue   = take & last2_q;
    y_d     = issue ? acc_d : y_q;
    busy_d  = start | (busy_q & ~(issue & (state_d == IDLE)));
    err_d   = err_q | abort | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_q     <= 1'b0;
      v1_q      <= 1'b0;
      f1_q      <= 1'b0;
      last1_q   <= 1'b0;
      tag1_q    <= 1'b0;
      v2_q      <= 1'b0;
      f2_q      <= 1'b0;
      last2_q   <= 1'b0;
      tag2_q    <= 1'b0;
      s_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      v1_q      <= v1_d;
      f1_q      <= start;
      last1_q   <= last;
      tag1_q    <= tag_d;
      v2_q      <= v1_q;
      f2_q      <= f1_q;
      last2_q   <= last1_q;
      tag2_q    <= tag1_q;
      s_q       <= sum;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= issue;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_da_lut_accumulator.sv
// tb_da_lut_accumulator: table-driven words plus corner sequences, y checked through an expected-value queue
module tb_da_lut_accumulator;
  localparam int ACC_W = 38;

  logic              clk = 0, reset = 1, in_valid = 0, in_first = 0;
  logic [7:0]        a [8];
  logic              lut_we = 0;
  logic [2:0]        lut_sel = 0;
  logic [7:0]        lut_addr = 0;
  logic [18:0]       lut_wdata = 0;
  logic [ACC_W-1:0]  y;
  logic              y_valid, busy, err;
  logic [15:0]       taps [64];
  longint            exp_q [$];
  int                errors = 0, checks = 0;

  typedef struct {
    logic [15:0] t0;
    logic [15:0] rest;
    int          gap;
    longint      exp_y;
  } vec_t;
  vec_t vecs [8];

  da_lut_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .lut_we(lut_we), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .y(y), .y_valid(y_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (y_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y_unexpected: got y=%0d expected no output", $signed(y));
      end else chk("y", $signed(y), exp_q.pop_front());
    end
  end

  task automatic set_taps(input logic [15:0] t0, input logic [15:0] rest);
    taps[0] = t0;
    for (int i = 1; i < 64; i++) taps[i] = rest;
  endtask

  task automatic drive_slice(input int b, input logic f);
    in_valid = 1;
    in_first = f;
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 8; j++) a[g][j] = taps[8*g+j][b];
    @(posedge clk); #1;
    in_valid = 0;
    in_first = 0;
  endtask

  task automatic send_word(input int gap_max, input longint exp_y);
    exp_q.push_back(exp_y);
    for (int k = 0; k < 16; k++) begin
      drive_slice(15 - k, k == 0);
      if (k < 15) repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    for (int g = 0; g < 8; g++) a[g] = 0;
    vecs[0] = '{16'h0003, 16'h0000, 0, 3};
    vecs[1] = '{16'hFFFF, 16'h0000, 0, -1};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 0, 2097088};
    vecs[3] = '{16'h8000, 16'h8000, 0, -2097152};
    vecs[4] = '{16'h0003, 16'h0000, 3, 3};
    vecs[5] = '{16'h8000, 16'h0000, 0, -32768};
    vecs[6] = '{16'h1234, 16'h0001, 2, 4723};
    vecs[7] = '{16'h0000, 16'hFFFF, 0, -63};
    #12;
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 0;
    for (int g = 0; g < 8; g++)
      for (int ad = 0; ad < 256; ad++) begin
        lut_we = 1; lut_sel = 3'(g); lut_addr = 8'(ad); lut_wdata = 19'($countones(8'(ad)));
        @(posedge clk); #1;
      end
    lut_we = 0;
    // words run back to back: each first slice immediately follows the previous last
    for (int v = 0; v < 8; v++) begin
      set_taps(vecs[v].t0, vecs[v].rest);
      send_word(vecs[v].gap, vecs[v].exp_y);
    end
    repeat (5) @(posedge clk);
    #1;
    set_taps(16'h0003, 16'h0000);
    exp_q.push_back(3);
    for (int k = 0; k < 16; k++) begin
      drive_slice(15 - k, k == 0);
      if (k == 7) chk("busy_mid", busy, 1);
    end
    @(negedge clk); chk("lat_e0", y_valid, 0);
    @(negedge clk); chk("lat_e1", y_valid, 0);
    @(negedge clk); chk("lat_e2", y_valid, 1);
    chk("busy_done", busy, 0);
    @(negedge clk); chk("pulse_end", y_valid, 0);
    @(posedge clk); #1;
    set_taps(16'h0007, 16'h0000);
    for (int k = 0; k < 5; k++) drive_slice(15 - k, k == 0);
    set_taps(16'h0005, 16'h0000);
    exp_q.push_back(5);
    drive_slice(15, 1);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 1);
    for (int k = 1; k < 16; k++) drive_slice(15 - k, 0);
    repeat (4) @(posedge clk);
    #1;
    set_taps(16'h0009, 16'h0000);
    for (int k = 0; k < 7; k++) drive_slice(15 - k, k == 0);
    #2 reset = 1;
    #1;
    chk("mid_rst_y", y, 0);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk); #1;
    reset = 0;
    set_taps(16'h0003, 16'h0000);
    send_word(0, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("err_clean", err, 0);
    drive_slice(3, 0);
    chk("drop_err", err, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
